soc_gpio_endpoint: RTL and testbench



---
 rtl/soc_gpio_endpoint.sv | 192 +++++++++++++++++++
 tb/tb_soc_gpio_endpoint.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/soc_gpio_endpoint.sv
// soc_gpio_endpoint
//   SoC-side endpoint for a bank of embedded FPGA I/Os. It synchronizes the
//   fabric-driven soc_out/soc_dir/config_done, sequences the active-low
//   isolation (io_isol_n) around fabric configuration, drives soc_in, and
//   exposes a 4-entry host register file with per-pin edge interrupts.
//
//   Registers: 0 DATA_OUT (R/W), 1 IRQ_MASK (R/W), 2 IRQ_STATUS (R, W1C),
//              3 PIN_STATE (RO).
//
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     config_done       fabric configuration complete (async)
//     soc_in[NUM_IO]    data to fabric (registered)
//     soc_out[NUM_IO]   data from fabric (async)
//     soc_dir[NUM_IO]   1 = endpoint drives bit, 0 = endpoint samples bit
//     io_isol_n         active-low isolation (registered)
//     host_we/addr/wdata  register write port
//     host_rdata        registered read data (1 cycle latency)
//     irq               registered |(IRQ_STATUS & IRQ_MASK)
//
//   Optional build macro SOC_GPIO_ANY_EDGE_IRQ_EN: falling edges also set
//   IRQ_STATUS (any-edge interrupt). Undefined: rising edges only.

// Per-pin edge detect and pin-state select.
module soc_gpio_lane (
  input  logic edge_en,
  input  logic out_s,
  input  logic out_q,
  input  logic dir_s,
  input  logic dir_q,
  input  logic dout,
  output logic edge_set,
  output logic pin
);
  // A bit only flags while it has been a fabric output for two samples,
  // so a direction flip can never look like a data edge.
  logic stable_in;
  assign stable_in = ~dir_s & ~dir_q;

`ifdef SOC_GPIO_ANY_EDGE_IRQ_EN
  assign edge_set = edge_en & stable_in & (out_s ^ out_q);
`else
  assign edge_set = edge_en & stable_in & out_s & ~out_q;
`endif

  assign pin = dir_s ? dout : out_s;
endmodule

module soc_gpio_endpoint #(
  parameter int NUM_IO        = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              config_done,
  output logic [NUM_IO-1:0] soc_in,
  input  logic [NUM_IO-1:0] soc_out,
  input  logic [NUM_IO-1:0] soc_dir,
  output logic              io_isol_n,
  input  logic              host_we,
  input  logic [1:0]        host_addr,
  input  logic [NUM_IO-1:0] host_wdata,
  output logic [NUM_IO-1:0] host_rdata,
  output logic              irq
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_STAT = 2'd2;
  localparam logic [1:0] A_PIN  = 2'd3;

  typedef enum logic [1:0] {ISOLATED, SETTLE, ACTIVE} state_t;

  // synchronizers + one history stage
  logic [SYNC_STAGES-1:0]             cfg_sync;
  logic [SYNC_STAGES-1:0][NUM_IO-1:0] out_sync, dir_sync;
  logic                               cfg_s;
  logic [NUM_IO-1:0]                  out_s, dir_s, out_q, dir_q;

  assign cfg_s = cfg_sync[SYNC_STAGES-1];
  assign out_s = out_sync[SYNC_STAGES-1];
  assign dir_s = dir_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_sync <= '0;
      out_sync <= '0;
      dir_sync <= '0;
      out_q    <= '0;
      dir_q    <= '0;
    end else begin
      cfg_sync <= {cfg_sync[SYNC_STAGES-2:0], config_done};
      out_sync <= {out_sync[SYNC_STAGES-2:0], soc_out};
      dir_sync <= {dir_sync[SYNC_STAGES-2:0], soc_dir};
      out_q    <= out_s;
      dir_q    <= dir_s;
    end
  end

  // isolation FSM
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ISOLATED;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      ISOLATED: if (cfg_s) state_nxt = SETTLE;
      SETTLE: begin
        if (!cfg_s)                state_nxt = ISOLATED;
        else if (cnt == CNT_LAST)  state_nxt = ACTIVE;
        else                       cnt_nxt   = cnt + CW'(1);
      end
      ACTIVE:   if (!cfg_s) state_nxt = ISOLATED;
      default:  state_nxt = ISOLATED;
    endcase
  end

  // armed is low in the first ACTIVE cycle: out_q then still holds a
  // pre-ACTIVE sample, so edges are ignored until it has been reloaded.
  logic armed, edge_en;
  always_ff @(posedge clk) begin
    if (reset) armed <= 1'b0;
    else       armed <= (state == ACTIVE);
  end
  assign edge_en = (state == ACTIVE) & armed;

  // registers
  logic [NUM_IO-1:0] data_out, irq_mask, irq_status;
  logic [NUM_IO-1:0] edge_set, pin_state, w1c, rd_mux;

  for (genvar i = 0; i < NUM_IO; i++) begin : g_lane
    soc_gpio_lane u_lane (
      .edge_en (edge_en),
      .out_s   (out_s[i]),
      .out_q   (out_q[i]),
      .dir_s   (dir_s[i]),
      .dir_q   (dir_q[i]),
      .dout    (data_out[i]),
      .edge_set(edge_set[i]),
      .pin     (pin_state[i])
    );
  end

  assign w1c = (host_we && host_addr == A_STAT) ? host_wdata : '0;

  always_comb begin
    rd_mux = '0;
    case (host_addr)
      A_DATA:  rd_mux = data_out;
      A_MASK:  rd_mux = irq_mask;
      A_STAT:  rd_mux = irq_status;
      A_PIN:   rd_mux = pin_state;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      irq_mask   <= '0;
      irq_status <= '0;
      host_rdata <= '0;
      irq        <= 1'b0;
      io_isol_n  <= 1'b0;
      soc_in     <= '0;
    end else begin
      if (host_we && host_addr == A_DATA) data_out <= host_wdata;
      if (host_we && host_addr == A_MASK) irq_mask <= host_wdata;
      // set dominates a same-cycle clear
      irq_status <= (irq_status & ~w1c) | edge_set;
      host_rdata <= rd_mux;
      irq        <= |(irq_status & irq_mask);
      // outputs follow the next state so they change on the transition edge
      io_isol_n  <= (state_nxt == ACTIVE);
      soc_in     <= (state_nxt == ACTIVE) ? (data_out & dir_s) : '0;
    end
  end
endmodule

// File: tb/tb_soc_gpio_endpoint.sv
module tb_soc_gpio_endpoint;
  logic       clk = 1'b0;
  logic       reset, config_done, host_we, io_isol_n, irq;
  logic [7:0] soc_in, soc_out, soc_dir, host_wdata, host_rdata;
  logic [1:0] host_addr;

  int n_cmp = 0;
  int n_bad = 0;

  // reference state
  logic [7:0] m_data, m_mask, m_stat, cur_out, cur_dir;

  soc_gpio_endpoint #(.NUM_IO(8), .SYNC_STAGES(2), .SETTLE_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .config_done(config_done),
    .soc_in(soc_in), .soc_out(soc_out), .soc_dir(soc_dir),
    .io_isol_n(io_isol_n), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    host_addr = a;
    @(negedge clk);
    d = host_rdata;
  endtask

  // counts edges until io_isol_n reaches lvl (bounded); flags soc_in leaks
  task automatic wait_isol(input logic lvl, output int n, output bit leak);
    n = 0; leak = 0;
    do begin
      @(negedge clk);
      n++;
      if (io_isol_n === 1'b0 && soc_in !== 8'h00) leak = 1;
    end while (io_isol_n !== lvl && n < 100);
  endtask

  function automatic logic [7:0] edges(input logic [7:0] o, input logic [7:0] n,
                                       input logic [7:0] dir);
`ifdef SOC_GPIO_ANY_EDGE_IRQ_EN
    return ~dir & (o ^ n);
`else
    return ~dir & n & ~o;
`endif
  endfunction

  initial begin
    logic [7:0] d, w;
    int n;
    bit leak;
    int op;

    reset = 1; config_done = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    soc_out = 0; soc_dir = 0;
    cyc(3);
    chk("rst_soc_in", soc_in, 8'h00);
    chk("rst_isol", io_isol_n, 1'b0);
    chk("rst_rdata", host_rdata, 8'h00);
    chk("rst_irq", irq, 1'b0);
    reset = 0;
    cyc(1);

    // settle sequence: DATA_OUT written while isolated must not leak
    soc_dir = 8'hFF;
    wr(2'd0, 8'h5A);
    cyc(3);
    chk("isolated_soc_in", soc_in, 8'h00);
    config_done = 1;
    wait_isol(1'b1, n, leak);
    chk("settle_latency", n, 19);
    chk("settle_leak", leak, 0);
    chk("active_soc_in", soc_in, 8'h5A);

    // DATA_OUT reaches soc_in one cycle after the write
    wr(2'd0, 8'hA5);
    cyc(1);
    chk("dout_a5", soc_in, 8'hA5);
    soc_dir = 8'h0F;
    cyc(4);
    chk("dout_dir0f", soc_in, 8'h05);
    soc_out = 8'h3C;
    cyc(4);
    rd(2'd3, d); chk("pin_state", d, 8'h35);
    rd(2'd2, d); chk("stat_hi_rise", d, 8'h30);
    rd(2'd0, d); chk("rd_data", d, 8'hA5);
    wr(2'd2, 8'hFF);
    rd(2'd2, d); chk("w1c_all", d, 8'h00);

    // masked interrupt on bit 0
    soc_dir = 8'h00; cyc(4);
    soc_out = 8'h00; cyc(4);
    wr(2'd2, 8'hFF);
    wr(2'd1, 8'h01);
    soc_out = 8'h01; cyc(4);
    rd(2'd2, d); chk("stat_b0", d, 8'h01);
    chk("irq_b0", irq, 1'b1);
    wr(2'd2, 8'h01); cyc(2);
    chk("irq_cleared", irq, 1'b0);
    rd(2'd2, d); chk("stat_cleared", d, 8'h00);
    soc_out = 8'h09; cyc(4);
    rd(2'd2, d); chk("stat_b3", d, 8'h08);
    chk("irq_masked", irq, 1'b0);

    // W1C on the same edge that sets bit 0: set wins
    soc_out = 8'h00; cyc(4);
    wr(2'd2, 8'hFF);
    soc_out = 8'h01;
    cyc(2);
    wr(2'd2, 8'h01);
    rd(2'd2, d); chk("set_beats_w1c", d, 8'h01);

    // config_done dropout while ACTIVE
    wr(2'd2, 8'hFF);
    soc_dir = 8'hF0; cyc(4);
    chk("pre_drop_soc_in", soc_in, 8'hA0);
    config_done = 0;
    wait_isol(1'b0, n, leak);
    chk("drop_latency", n, 3);
    chk("drop_soc_in", soc_in, 8'h00);
    soc_out = 8'h0E; cyc(5);
    rd(2'd2, d); chk("isolated_no_edge", d, 8'h00);
    rd(2'd1, d); chk("mask_kept", d, 8'h01);

    // dropout mid-SETTLE restarts the count
    config_done = 1; cyc(8);
    chk("mid_settle_isol", io_isol_n, 1'b0);
    config_done = 0; cyc(4);
    config_done = 1;
    wait_isol(1'b1, n, leak);
    chk("resettle_latency", n, 19);

    // falling edge on bit 2
    soc_dir = 8'h00; cyc(4);
    wr(2'd2, 8'hFF);
    soc_out = 8'h0A; cyc(4);
    rd(2'd2, d);
`ifdef SOC_GPIO_ANY_EDGE_IRQ_EN
    chk("fall_b2", d, 8'h04);
`else
    chk("fall_b2", d, 8'h00);
`endif

    // randomized phase against the register/pin model
    wr(2'd2, 8'hFF);
    m_data = 8'hA5; m_mask = 8'h01; m_stat = 8'h00;
    cur_out = soc_out; cur_dir = soc_dir;
    for (int it = 0; it < 30; it++) begin
      op = int'($urandom_range(0, 5));
      w = 8'($urandom);
      case (op)
        0: begin m_stat |= edges(cur_out, w, cur_dir); cur_out = w; soc_out = w; end
        1: begin cur_dir = w; soc_dir = w; end
        2: begin m_data = w; wr(2'd0, w); end
        3: begin m_mask = w; wr(2'd1, w); end
        4: begin m_stat &= ~w; wr(2'd2, w); end
        default: wr(2'd3, w);
      endcase
      cyc(4);
      rd(2'd0, d); chk("rnd_data", d, m_data);
      rd(2'd1, d); chk("rnd_mask", d, m_mask);
      rd(2'd2, d); chk("rnd_stat", d, m_stat);
      rd(2'd3, d); chk("rnd_pin", d, (cur_dir & m_data) | (~cur_dir & cur_out));
      chk("rnd_soc_in", soc_in, m_data & cur_dir);
      chk("rnd_irq", irq, |(m_stat & m_mask));
    end

    // reset mid-operation with config_done held high
    soc_dir = 8'hFF; cyc(4);
    reset = 1;
    cyc(1);
    chk("mid_rst_isol", io_isol_n, 1'b0);
    chk("mid_rst_soc_in", soc_in, 8'h00);
    chk("mid_rst_irq", irq, 1'b0);
    chk("mid_rst_rdata", host_rdata, 8'h00);
    reset = 0;
    wait_isol(1'b1, n, leak);
    chk("post_rst_latency", n, 19);
    rd(2'd0, d); chk("post_rst_data", d, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
